draw_scheduler: RTL and testbench

//  Per-frame sequencer for the shared sprite draw unit and framebuffer write port. On each

---
 rtl/draw_scheduler_if.sv | 45 ++++
 rtl/draw_scheduler.sv | 163 ++++++++++++++++
 tb/tb_draw_scheduler.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/draw_scheduler_if.sv
// Signal bundle between the frame sequencer, the object table, the sprite draw unit and the framebuffer port.
// The master modport is the sequencer side.
interface draw_scheduler_if #(
    parameter int IDX_W = 3
);
    logic             frame_start;
    logic [IDX_W-1:0] obj_idx;
    logic             obj_valid;
    logic [9:0]       obj_x;
    logic [9:0]       obj_y;
    logic [2:0]       obj_sprite;
    logic             plot;
    logic [9:0]       x_pos;
    logic [9:0]       y_pos;
    logic [2:0]       sprite_sel;
    logic [9:0]       spr_x;
    logic [9:0]       spr_y;
    logic             spr_we;
    logic [2:0]       spr_color;
    logic             draw_done;
    logic [9:0]       fb_x;
    logic [9:0]       fb_y;
    logic [2:0]       fb_color;
    logic             fb_we;
    logic             busy;
    logic             frame_done;
    logic             overrun;
    logic             timeout_err;

    modport master (
        input  frame_start, obj_valid, obj_x, obj_y, obj_sprite,
        input  spr_x, spr_y, spr_we, spr_color, draw_done,
        output obj_idx, plot, x_pos, y_pos, sprite_sel,
        output fb_x, fb_y, fb_color, fb_we,
        output busy, frame_done, overrun, timeout_err
    );

    modport slave (
        output frame_start, obj_valid, obj_x, obj_y, obj_sprite,
        output spr_x, spr_y, spr_we, spr_color, draw_done,
        input  obj_idx, plot, x_pos, y_pos, sprite_sel,
        input  fb_x, fb_y, fb_color, fb_we,
        input  busy, frame_done, overrun, timeout_err
    );
endinterface

// File: rtl/draw_scheduler.sv
// Per-frame sequencer: clears the screen, then walks the object table launching one sprite draw
// per valid slot and owning the framebuffer write port for the whole frame.
module draw_scheduler #(
    parameter int         NUM_OBJ     = 8,
    parameter int         SCREEN_W    = 320,
    parameter int         SCREEN_H    = 240,
    parameter logic [2:0] CLEAR_COLOR = 3'b000,
    parameter int         TIMEOUT     = 4095
) (
    input  logic              clk,
    input  logic              reset_n,
    draw_scheduler_if.master  bus
);
    localparam int IDX_W  = $clog2(NUM_OBJ);
    localparam int TCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FETCH, S_WAIT_RD, S_LAUNCH, S_WAIT_DONE, S_NEXT, S_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [9:0]        cx_reg, cx_next, cy_reg, cy_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [TCNT_W-1:0] tcnt_reg, tcnt_next;
    logic [9:0]        x_pos_reg, x_pos_next, y_pos_reg, y_pos_next;
    logic [2:0]        sel_reg, sel_next;
    logic              overrun_reg, overrun_next;
    logic              terr_reg, terr_next;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= S_IDLE;
            cx_reg      <= '0;
            cy_reg      <= '0;
            idx_reg     <= '0;
            tcnt_reg    <= '0;
            x_pos_reg   <= '0;
            y_pos_reg   <= '0;
            sel_reg     <= '0;
            overrun_reg <= 1'b0;
            terr_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cx_reg      <= cx_next;
            cy_reg      <= cy_next;
            idx_reg     <= idx_next;
            tcnt_reg    <= tcnt_next;
            x_pos_reg   <= x_pos_next;
            y_pos_reg   <= y_pos_next;
            sel_reg     <= sel_next;
            overrun_reg <= overrun_next;
            terr_reg    <= terr_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cx_next      = cx_reg;
        cy_next      = cy_reg;
        idx_next     = idx_reg;
        tcnt_next    = tcnt_reg;
        x_pos_next   = x_pos_reg;
        y_pos_next   = y_pos_reg;
        sel_next     = sel_reg;
        terr_next    = terr_reg;
        // Any frame_start outside IDLE (including the DONE cycle) is dropped and flagged.
        overrun_next = overrun_reg | (bus.frame_start && (state_reg != S_IDLE));

        case (state_reg)
            S_IDLE: begin
                if (bus.frame_start) begin
                    state_next = S_CLEAR;
                    cx_next    = '0;
                    cy_next    = '0;
                end
            end
            S_CLEAR: begin
                if (cx_reg == 10'(SCREEN_W - 1)) begin
                    cx_next = '0;
                    if (cy_reg == 10'(SCREEN_H - 1)) begin
                        state_next = S_FETCH;
                        idx_next   = '0;
                    end else begin
                        cy_next = cy_reg + 10'd1;
                    end
                end else begin
                    cx_next = cx_reg + 10'd1;
                end
            end
            S_FETCH: state_next = S_WAIT_RD;
            S_WAIT_RD: begin
                if (bus.obj_valid) begin
                    state_next = S_LAUNCH;
                    x_pos_next = bus.obj_x;
                    y_pos_next = bus.obj_y;
                    sel_next   = bus.obj_sprite;
                end else begin
                    state_next = S_NEXT;
                end
            end
            S_LAUNCH: begin
                tcnt_next  = '0;
                state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // tcnt_reg==0 marks the first cycle after launch, where draw_done is stale.
                tcnt_next = tcnt_reg + 1'b1;
                if (bus.draw_done && (tcnt_reg != '0)) begin
                    state_next = S_NEXT;
                end else if (tcnt_reg == TCNT_W'(TIMEOUT - 1)) begin
                    terr_next  = 1'b1;
                    state_next = S_NEXT;
                end
            end
            S_NEXT: begin
                if (idx_reg == IDX_W'(NUM_OBJ - 1)) begin
                    state_next = S_DONE;
                end else begin
                    idx_next   = idx_reg + 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_DONE: begin
                idx_next   = '0;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign bus.obj_idx     = idx_reg;
    assign bus.plot        = (state_reg == S_LAUNCH);
    assign bus.x_pos       = x_pos_reg;
    assign bus.y_pos       = y_pos_reg;
    assign bus.sprite_sel  = sel_reg;
    assign bus.busy        = (state_reg != S_IDLE);
    assign bus.frame_done  = (state_reg == S_DONE);
    assign bus.overrun     = overrun_reg;
    assign bus.timeout_err = terr_reg;

    // The draw unit only reaches the framebuffer while a sprite it was asked to draw is live.
    always_comb begin
        bus.fb_we    = 1'b0;
        bus.fb_x     = '0;
        bus.fb_y     = '0;
        bus.fb_color = '0;
        case (state_reg)
            S_CLEAR: begin
                bus.fb_we    = 1'b1;
                bus.fb_x     = cx_reg;
                bus.fb_y     = cy_reg;
                bus.fb_color = CLEAR_COLOR;
            end
            S_LAUNCH, S_WAIT_DONE: begin
                bus.fb_we    = bus.spr_we;
                bus.fb_x     = bus.spr_x;
                bus.fb_y     = bus.spr_y;
                bus.fb_color = bus.spr_color;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler on a 4x2 screen: frame timelines are derived from the per-slot
// state sequence and compared cycle by cycle against the DUT outputs.
module tb_draw_scheduler;
    localparam int NUM_OBJ = 8;
    localparam int IDX_W   = 3;
    localparam int SW      = 4;
    localparam int SH      = 2;
    localparam int TO      = 15;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    draw_scheduler_if #(.IDX_W(IDX_W)) bus ();

    draw_scheduler #(
        .NUM_OBJ(NUM_OBJ), .SCREEN_W(SW), .SCREEN_H(SH),
        .CLEAR_COLOR(3'b000), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    // Object table with a one-cycle registered read.
    logic       tbl_valid [NUM_OBJ];
    logic [9:0] tbl_x     [NUM_OBJ];
    logic [9:0] tbl_y     [NUM_OBJ];
    logic [2:0] tbl_spr   [NUM_OBJ];
    int         lat_m     [NUM_OBJ];   // draw_done delay after plot; 0 = never

    always @(posedge clk) begin
        bus.obj_valid  <= tbl_valid[bus.obj_idx];
        bus.obj_x      <= tbl_x[bus.obj_idx];
        bus.obj_y      <= tbl_y[bus.obj_idx];
        bus.obj_sprite <= tbl_spr[bus.obj_idx];
    end

    int   checks = 0;
    int   errors = 0;
    logic ovr_m  = 1'b0;
    logic err_m  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_table(input logic [NUM_OBJ-1:0] mask);
        for (int i = 0; i < NUM_OBJ; i++) begin
            tbl_valid[i] = mask[i];
            tbl_x[i]     = 10'($urandom_range(0, 1023));
            tbl_y[i]     = 10'($urandom_range(0, 1023));
            tbl_spr[i]   = 3'($urandom_range(0, 7));
            lat_m[i]     = $urandom_range(0, TO);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_plot"}, 32'(bus.plot), 32'd0);
        chk({tag, "_fb_we"}, 32'(bus.fb_we), 32'd0);
        chk({tag, "_fb_x"}, 32'(bus.fb_x), 32'd0);
        chk({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
        chk({tag, "_overrun"}, 32'(bus.overrun), 32'd0);
        chk({tag, "_timeout_err"}, 32'(bus.timeout_err), 32'd0);
        chk({tag, "_x_pos"}, 32'(bus.x_pos), 32'd0);
        chk({tag, "_obj_idx"}, 32'(bus.obj_idx), 32'd0);
    endtask

    // One frame. frame_start is driven in relative cycle 0, the sweep occupies cycles 1..SW*SH.
    // Each slot then costs FETCH+WAIT_RD+NEXT, plus LAUNCH and E WAIT_DONE cycles when valid.
    task automatic run_frame(input string tag, input int pulse_mid, input bit pulse_done,
                             input int abort_after_plot);
        int  fetch_c[NUM_OBJ];
        int  l_c[NUM_OBJ];
        int  e_c[NUM_OBJ];
        bit  tmo[NUM_OBJ];
        int  t, done_c, abort_c, win, n_plots;
        bit  exp_we, fs;
        t = 1 + SW * SH;
        abort_c = -1;
        n_plots = 0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            fetch_c[i] = t;
            l_c[i]     = -100;
            tmo[i]     = !(lat_m[i] >= 2 && lat_m[i] <= TO);
            e_c[i]     = tmo[i] ? TO : lat_m[i];
            if (tbl_valid[i]) begin
                l_c[i] = t + 2;
                if (abort_after_plot >= 0 && abort_c < 0) abort_c = l_c[i] + abort_after_plot;
                t = t + 4 + e_c[i];
            end else begin
                t = t + 3;
            end
        end
        done_c = t;

        @(negedge clk);
        reset_n = 1'b1;
        bus.frame_start = 1'b1;
        bus.draw_done = 1'b0;
        #1;
        chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);

        for (int n = 1; n <= done_c + 2; n++) begin
            @(negedge clk);
            fs = (n == pulse_mid) || (pulse_done && n == done_c);
            bus.frame_start = fs;
            bus.spr_we    = 1'($urandom_range(0, 1));
            bus.spr_x     = 10'($urandom_range(0, 1023));
            bus.spr_y     = 10'($urandom_range(0, 1023));
            bus.spr_color = 3'($urandom_range(0, 7));
            win = -1;
            for (int i = 0; i < NUM_OBJ; i++)
                if (tbl_valid[i] && n >= l_c[i] && n <= l_c[i] + e_c[i]) win = i;
            bus.draw_done = (win < 0) ? 1'($urandom_range(0, 3) == 0) : 1'b0;
            for (int i = 0; i < NUM_OBJ; i++)
                if (tbl_valid[i] && lat_m[i] >= 1 && lat_m[i] <= TO && n == l_c[i] + lat_m[i])
                    bus.draw_done = 1'b1;
            reset_n = (n == abort_c) ? 1'b0 : 1'b1;
            #1;

            chk({tag, "_busy"}, 32'(bus.busy), 32'(n <= done_c));
            chk({tag, "_frame_done"}, 32'(bus.frame_done), 32'(n == done_c));
            chk({tag, "_overrun"}, 32'(bus.overrun), 32'(ovr_m));
            chk({tag, "_timeout_err"}, 32'(bus.timeout_err), 32'(err_m));
            chk({tag, "_plot"}, 32'(bus.plot), 32'(win >= 0 && n == l_c[win]));
            if (n <= SW * SH) exp_we = 1'b1;
            else if (win >= 0) exp_we = bus.spr_we;
            else exp_we = 1'b0;
            chk({tag, "_fb_we"}, 32'(bus.fb_we), 32'(exp_we));
            if (n <= SW * SH) begin
                chk({tag, "_clr_x"}, 32'(bus.fb_x), 32'((n - 1) % SW));
                chk({tag, "_clr_y"}, 32'(bus.fb_y), 32'((n - 1) / SW));
                chk({tag, "_clr_color"}, 32'(bus.fb_color), 32'd0);
            end else if (win >= 0 && exp_we) begin
                chk({tag, "_fwd_x"}, 32'(bus.fb_x), 32'(bus.spr_x));
                chk({tag, "_fwd_y"}, 32'(bus.fb_y), 32'(bus.spr_y));
                chk({tag, "_fwd_color"}, 32'(bus.fb_color), 32'(bus.spr_color));
            end
            if (win >= 0) begin
                chk({tag, "_x_pos"}, 32'(bus.x_pos), 32'(tbl_x[win]));
                chk({tag, "_y_pos"}, 32'(bus.y_pos), 32'(tbl_y[win]));
                chk({tag, "_sprite_sel"}, 32'(bus.sprite_sel), 32'(tbl_spr[win]));
                if (n == l_c[win]) n_plots++;
            end
            for (int i = 0; i < NUM_OBJ; i++)
                if (n == fetch_c[i]) chk({tag, "_obj_idx"}, 32'(bus.obj_idx), 32'(i));

            if (n == abort_c) begin
                @(negedge clk);
                reset_n = 1'b1;
                bus.frame_start = 1'b0;
                bus.draw_done = 1'b0;
                #1;
                ovr_m = 1'b0;
                err_m = 1'b0;
                check_idle_zero({tag, "_abort"});
                $display("[%s] aborted by reset at cycle %0d, checks=%0d errors=%0d", tag, n, checks, errors);
                return;
            end
            if (fs && n <= done_c) ovr_m = 1'b1;
            if (win >= 0 && tmo[win] && n == l_c[win] + e_c[win]) err_m = 1'b1;
        end
        bus.frame_start = 1'b0;
        $display("[%s] frame done at cycle %0d, plots=%0d, checks=%0d errors=%0d",
                 tag, done_c, n_plots, checks, errors);
    endtask

    initial begin
        bus.frame_start = 1'b0;
        bus.spr_we = 1'b0;
        bus.spr_x = '0;
        bus.spr_y = '0;
        bus.spr_color = '0;
        bus.draw_done = 1'b0;
        rand_table('0);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_idle_zero("reset");
        $display("[reset] checks=%0d errors=%0d", checks, errors);

        // Empty table.
        rand_table(8'b0000_0000);
        run_frame("empty", -1, 1'b0, -1);

        // Slots 1 and 5 valid with fixed contents.
        rand_table(8'b0010_0010);
        tbl_x[1] = 10'd100; tbl_y[1] = 10'd50;  tbl_spr[1] = 3'd2; lat_m[1] = 12;
        tbl_x[5] = 10'd10;  tbl_y[5] = 10'd200; tbl_spr[5] = 3'd7; lat_m[5] = 9;
        run_frame("two_slots", -1, 1'b0, -1);

        // Slot 2 never finishes, slot 6 still drawn afterwards.
        rand_table(8'b0100_0100);
        lat_m[2] = 0;
        lat_m[6] = 5;
        run_frame("timeout", -1, 1'b0, -1);

        // Stale draw_done in the first wait cycle, and draw_done exactly at the limit.
        rand_table(8'b1000_0001);
        lat_m[0] = 1;
        lat_m[7] = TO;
        run_frame("edge_done", -1, 1'b0, -1);

        // frame_start mid-clear and in the DONE cycle.
        rand_table(8'($urandom_range(0, 255)));
        run_frame("overrun", 3, 1'b1, -1);

        for (int r = 0; r < 6; r++) begin
            rand_table(8'($urandom_range(0, 255)));
            run_frame("random", -1, 1'b0, -1);
        end

        // Reset while waiting on a draw that never completes, then a clean frame.
        rand_table(8'b0000_1001);
        lat_m[0] = 0;
        run_frame("abort", -1, 1'b0, 5);
        rand_table(8'b1010_0110);
        run_frame("after_abort", -1, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
